// File: rtl/exe_alu_unit_pkg.sv
// Shared encodings for the execute stage: ALU funct codes, branch opcodes
// and REGIMM rt selectors.
package exe_pkg;

  typedef enum logic [5:0] {
    FN_SLL   = 6'h00,
    FN_SRL   = 6'h02,
    FN_SRA   = 6'h03,
    FN_SLLV  = 6'h04,
    FN_SRLV  = 6'h06,
    FN_SRAV  = 6'h07,
    FN_LUI   = 6'h0F,
    FN_MFHI  = 6'h10,
    FN_MTHI  = 6'h11,
    FN_MFLO  = 6'h12,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1A,
    FN_DIVU  = 6'h1B,
    FN_ADD   = 6'h20,
    FN_ADDU  = 6'h21,
    FN_SUB   = 6'h22,
    FN_SUBU  = 6'h23,
    FN_AND   = 6'h24,
    FN_OR    = 6'h25,
    FN_XOR   = 6'h26,
    FN_NOR   = 6'h27,
    FN_SLT   = 6'h2A,
    FN_SLTU  = 6'h2B
  } alu_op_e;

  localparam logic [5:0] OPC_REGIMM = 6'h01;
  localparam logic [5:0] OPC_J      = 6'h02;
  localparam logic [5:0] OPC_JAL    = 6'h03;
  localparam logic [5:0] OPC_BEQ    = 6'h04;
  localparam logic [5:0] OPC_BNE    = 6'h05;
  localparam logic [5:0] OPC_BLEZ   = 6'h06;
  localparam logic [5:0] OPC_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

endpackage

// File: rtl/exe_alu_unit_if.sv
// Operand/result bundle between the EXE stage control and the ALU unit.
interface exe_alu_if;
  logic        Valid_IN;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic [5:0]  ALU_control;
  logic [4:0]  shamt;
  logic        jr_flag;
  logic [31:0] Instr;
  logic [31:0] aluResult;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        taken;

  modport master (
    output Valid_IN, OperandA, OperandB, ALU_control, shamt, jr_flag, Instr,
    input  aluResult, HI, LO, taken
  );

  modport slave (
    input  Valid_IN, OperandA, OperandB, ALU_control, shamt, jr_flag, Instr,
    output aluResult, HI, LO, taken
  );
endinterface

// File: rtl/exe_alu_unit_branch_compare.sv
// Branch/jump resolution: decodes the opcode (and rt for REGIMM) and compares
// OperandA against OperandB or zero.
module branch_compare
  import exe_pkg::*;
(
  input  logic        jr_flag,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] instr,
  output logic        taken
);

  logic [5:0] opcode;
  logic [4:0] rt;
  logic       a_neg;
  logic       a_zero;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign rt           = instr[20:16];
  assign a_neg        = a[31];
  assign a_zero       = (a == 32'd0);
  assign unused_instr = ^{instr[25:21], instr[15:0]};

  always_comb begin
    taken = 1'b0;
    if (jr_flag) begin
      taken = 1'b1;
    end else begin
      case (opcode)
        OPC_BEQ:  taken = (a == b);
        OPC_BNE:  taken = (a != b);
        OPC_BLEZ: taken = a_neg | a_zero;
        OPC_BGTZ: taken = ~a_neg & ~a_zero;
        OPC_J,
        OPC_JAL:  taken = 1'b1;
        OPC_REGIMM: begin
          case (rt)
            RT_BLTZ,  RT_BLTZAL: taken = a_neg;
            RT_BGEZ,  RT_BGEZAL: taken = ~a_neg;
            default:             taken = 1'b0;
          endcase
        end
        default:  taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/exe_alu_unit.sv
// Execute-stage ALU: combinational integer datapath, HI/LO registers fed by
// single-cycle multiply/divide, and the branch comparator.
module exe_alu_unit
  import exe_pkg::*;
(
  input  logic     CLK,
  input  logic     RESET,
  exe_alu_if.slave bus
);

  logic [31:0] a, b, result;
  logic [4:0]  sh_var;
  alu_op_e     op;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic [63:0] prod_s, prod_u;
  logic        div_ovf, div_zero;
  logic signed [31:0] sa, sdiv, quo_s, rem_s;
  logic [31:0] udiv, quo_u, rem_u;

  assign a      = bus.OperandA;
  assign b      = bus.OperandB;
  assign sh_var = a[4:0];
  assign op     = alu_op_e'(bus.ALU_control);

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Swapping the divisor for 1 keeps the dividers trap-free; for INT_MIN/-1
  // it also yields exactly the required LO = INT_MIN, HI = 0.
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign sa       = $signed(a);
  assign sdiv     = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
  assign quo_s    = sa / sdiv;
  assign rem_s    = sa % sdiv;
  assign udiv     = div_zero ? 32'd1 : b;
  assign quo_u    = a / udiv;
  assign rem_u    = a % udiv;

  always_comb begin
    result = a + b;
    case (op)
      FN_ADD, FN_ADDU: result = a + b;
      FN_SUB, FN_SUBU: result = a - b;
      FN_AND:   result = a & b;
      FN_OR:    result = a | b;
      FN_XOR:   result = a ^ b;
      FN_NOR:   result = ~(a | b);
      FN_SLT:   result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      FN_SLTU:  result = (a < b) ? 32'd1 : 32'd0;
      FN_SLL:   result = b << bus.shamt;
      FN_SRL:   result = b >> bus.shamt;
      FN_SRA:   result = $signed(b) >>> bus.shamt;
      FN_SLLV:  result = b << sh_var;
      FN_SRLV:  result = b >> sh_var;
      FN_SRAV:  result = $signed(b) >>> sh_var;
      FN_LUI:   result = {b[15:0], 16'd0};
      FN_MFHI:  result = hi_q;
      FN_MFLO:  result = lo_q;
      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: result = 32'd0;
      default:  result = a + b;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (op)
      FN_MULT:  {hi_d, lo_d} = prod_s;
      FN_MULTU: {hi_d, lo_d} = prod_u;
      FN_DIV: begin
        if (!div_zero) begin
          lo_d = quo_s;
          hi_d = rem_s;
        end
      end
      FN_DIVU: begin
        if (!div_zero) begin
          lo_d = quo_u;
          hi_d = rem_u;
        end
      end
      FN_MTHI:  hi_d = a;
      FN_MTLO:  lo_d = a;
      default: ;
    endcase
  end

  // Bubbles leave HI/LO untouched; any non-writing op just reloads the same value.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (bus.Valid_IN) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.aluResult = result;
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;

  branch_compare u_cmp (
    .jr_flag (bus.jr_flag),
    .a       (a),
    .b       (b),
    .instr   (bus.Instr),
    .taken   (bus.taken)
  );

endmodule

// File: tb/tb_exe_alu_unit.sv
// Directed bench for exe_alu_unit: ALU ops, HI/LO multiply/divide behaviour,
// async reset and branch decisions against hand-computed values.
module tb_exe_alu_unit;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  exe_alu_if bus ();

  exe_alu_unit dut (
    .CLK   (clk),
    .RESET (reset_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Drives one operation set and lets the combinational outputs settle.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic valid);
    bus.ALU_control = op;
    bus.OperandA    = a;
    bus.OperandB    = b;
    bus.shamt       = sh;
    bus.Valid_IN    = valid;
    #1;
  endtask

  task automatic applyBranch(input logic [31:0] instr, input logic jr, input logic [31:0] a,
                             input logic [31:0] b);
    bus.Instr    = instr;
    bus.jr_flag  = jr;
    bus.OperandA = a;
    bus.OperandB = b;
    #1;
  endtask

  // Writes on the next rising edge, then samples just after it.
  task automatic clockWrite(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic valid);
    @(negedge clk);
    applyStimulus(op, a, b, 5'd0, valid);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    bus.Instr   = 32'd0;
    bus.jr_flag = 1'b0;
    applyStimulus(6'h3F, 32'd0, 32'd0, 5'd0, 1'b0);
    #12;
    checkOutput("reset_hi", bus.HI, 32'd0);
    checkOutput("reset_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
    checkOutput("add_wrap", bus.aluResult, 32'h8000_0000);
    applyStimulus(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    checkOutput("slt", bus.aluResult, 32'd1);
    applyStimulus(6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    checkOutput("sltu", bus.aluResult, 32'd0);
    applyStimulus(6'h23, 32'd5, 32'd7, 5'd0, 1'b0);
    checkOutput("subu", bus.aluResult, 32'hFFFF_FFFE);
    applyStimulus(6'h27, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 1'b0);
    checkOutput("nor", bus.aluResult, 32'hF0F0_FF0F);
    applyStimulus(6'h26, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 1'b0);
    checkOutput("xor", bus.aluResult, 32'hF0F0_F0F0);
    applyStimulus(6'h03, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
    checkOutput("sra", bus.aluResult, 32'hF800_0000);
    applyStimulus(6'h02, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
    checkOutput("srl", bus.aluResult, 32'h0800_0000);
    applyStimulus(6'h00, 32'd0, 32'd1, 5'd31, 1'b0);
    checkOutput("sll", bus.aluResult, 32'h8000_0000);
    applyStimulus(6'h06, 32'd36, 32'h8000_0000, 5'd0, 1'b0);
    checkOutput("srlv", bus.aluResult, 32'h0800_0000);
    applyStimulus(6'h07, 32'd8, 32'h8000_0000, 5'd0, 1'b0);
    checkOutput("srav", bus.aluResult, 32'hFF80_0000);
    applyStimulus(6'h0F, 32'd0, 32'h0000_1234, 5'd0, 1'b0);
    checkOutput("lui", bus.aluResult, 32'h1234_0000);
    applyStimulus(6'h3F, 32'h0000_1000, 32'h0000_0020, 5'd0, 1'b0);
    checkOutput("default_add", bus.aluResult, 32'h0000_1020);

    // MULT -2 x 3: HI/LO keep old value until the edge.
    @(negedge clk);
    applyStimulus(6'h18, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1);
    checkOutput("mult_result", bus.aluResult, 32'd0);
    checkOutput("mult_hi_before", bus.HI, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mult_hi", bus.HI, 32'hFFFF_FFFF);
    checkOutput("mult_lo", bus.LO, 32'hFFFF_FFFA);
    @(negedge clk);
    applyStimulus(6'h12, 32'd0, 32'd0, 5'd0, 1'b1);
    checkOutput("mflo", bus.aluResult, 32'hFFFF_FFFA);

    clockWrite(6'h19, 32'hFFFF_FFFF, 32'd2, 1'b1);
    checkOutput("multu_hi", bus.HI, 32'd1);
    checkOutput("multu_lo", bus.LO, 32'hFFFF_FFFE);

    clockWrite(6'h1A, 32'hFFFF_FFF9, 32'd2, 1'b1);
    checkOutput("div_lo", bus.LO, 32'hFFFF_FFFD);
    checkOutput("div_hi", bus.HI, 32'hFFFF_FFFF);
    clockWrite(6'h1B, 32'd5, 32'd0, 1'b1);
    checkOutput("divu0_lo", bus.LO, 32'hFFFF_FFFD);
    checkOutput("divu0_hi", bus.HI, 32'hFFFF_FFFF);
    clockWrite(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    checkOutput("div_ovf_lo", bus.LO, 32'h8000_0000);
    checkOutput("div_ovf_hi", bus.HI, 32'd0);
    clockWrite(6'h1B, 32'hFFFF_FFFF, 32'd16, 1'b1);
    checkOutput("divu_lo", bus.LO, 32'h0FFF_FFFF);
    checkOutput("divu_hi", bus.HI, 32'h0000_000F);

    clockWrite(6'h11, 32'h0000_1234, 32'd0, 1'b0);
    checkOutput("mthi_bubble", bus.HI, 32'h0000_000F);
    clockWrite(6'h11, 32'h0000_1234, 32'd0, 1'b1);
    checkOutput("mthi", bus.HI, 32'h0000_1234);
    clockWrite(6'h13, 32'h0000_ABCD, 32'd0, 1'b1);
    checkOutput("mtlo", bus.LO, 32'h0000_ABCD);
    checkOutput("mtlo_hi_kept", bus.HI, 32'h0000_1234);
    @(negedge clk);
    applyStimulus(6'h10, 32'd0, 32'd0, 5'd0, 1'b1);
    checkOutput("mfhi", bus.aluResult, 32'h0000_1234);

    // Asynchronous reset mid-cycle, with a pending MTLO held across an edge.
    applyStimulus(6'h13, 32'h5555_5555, 32'd0, 5'd0, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_hi", bus.HI, 32'd0);
    checkOutput("async_rst_lo", bus.LO, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_held_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    applyBranch({6'h04, 26'd0}, 1'b0, 32'd5, 32'd5);
    checkOutput("beq", {31'd0, bus.taken}, 32'd1);
    applyBranch({6'h05, 26'd0}, 1'b0, 32'd5, 32'd5);
    checkOutput("bne", {31'd0, bus.taken}, 32'd0);
    applyBranch({6'h06, 26'd0}, 1'b0, 32'd0, 32'd9);
    checkOutput("blez_zero", {31'd0, bus.taken}, 32'd1);
    applyBranch({6'h06, 26'd0}, 1'b0, 32'h8000_0000, 32'd0);
    checkOutput("blez_neg", {31'd0, bus.taken}, 32'd1);
    applyBranch({6'h07, 26'd0}, 1'b0, 32'd0, 32'd0);
    checkOutput("bgtz_zero", {31'd0, bus.taken}, 32'd0);
    applyBranch({6'h07, 26'd0}, 1'b0, 32'd5, 32'd0);
    checkOutput("bgtz_pos", {31'd0, bus.taken}, 32'd1);
    applyBranch({6'h01, 5'd0, 5'h01, 16'd0}, 1'b0, 32'hFFFF_FFFF, 32'd0);
    checkOutput("bgez_neg", {31'd0, bus.taken}, 32'd0);
    applyBranch({6'h01, 5'd0, 5'h00, 16'd0}, 1'b0, 32'hFFFF_FFFF, 32'd0);
    checkOutput("bltz_neg", {31'd0, bus.taken}, 32'd1);
    applyBranch({6'h01, 5'd0, 5'h10, 16'd0}, 1'b0, 32'd0, 32'd0);
    checkOutput("bltzal_zero", {31'd0, bus.taken}, 32'd0);
    applyBranch({6'h01, 5'd0, 5'h11, 16'd0}, 1'b0, 32'd0, 32'd0);
    checkOutput("bgezal_zero", {31'd0, bus.taken}, 32'd1);
    applyBranch({6'h01, 5'd0, 5'h02, 16'd0}, 1'b0, 32'hFFFF_FFFF, 32'd0);
    checkOutput("regimm_other", {31'd0, bus.taken}, 32'd0);
    applyBranch({6'h02, 26'd0}, 1'b0, 32'd0, 32'd0);
    checkOutput("j", {31'd0, bus.taken}, 32'd1);
    applyBranch({6'h03, 26'd0}, 1'b0, 32'd0, 32'd0);
    checkOutput("jal", {31'd0, bus.taken}, 32'd1);
    applyBranch(32'd0, 1'b1, 32'd0, 32'd0);
    checkOutput("jr", {31'd0, bus.taken}, 32'd1);
    applyBranch({6'h08, 26'd0}, 1'b0, 32'd3, 32'd3);
    checkOutput("addi_not_branch", {31'd0, bus.taken}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
